alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command sequencer in front of the 16-bit ALU (3-bit opcode, accumulator, carry, registered zero flag).
//  Queues operand/opcode commands from a requester in a small FIFO and issues one at a time.
//  Holds ALU operands stable for the ALU latency, then captures result and flags into a response register.
//  Optional chaining: a command may take the last captured result as operand A.
// PARAMETERS
//  WIDTH        16  datapath width of operands and result
//  FIFO_DEPTH   4   command FIFO entries; power of 2, >= 2
//  ALU_LATENCY  1   edges after operand issue before ALU outputs (incl. zero flag DFF) are valid; >= 1
// PORTS
//  iClock           in   1              rising-edge clock
//  iReset_n         in   1              asynchronous active-low reset
//  iCmdValid        in   1              command offered
//  oCmdReady        out  1              FIFO can accept (= !full)
//  iCmdOpcode       in   3              ALU opcode; 000-100 logic, 101-111 arithmetic
//  iCmdA            in   WIDTH          operand A (ignored if iCmdUseAcc)
//  iCmdB            in   WIDTH          operand B
//  iCmdUseAcc       in   1              1: operand A = last captured result
//  oAluA            out  WIDTH          to ALU iA
//  oAluB            out  WIDTH          to ALU iB
//  oAluOpcode       out  3              to ALU iOpcode
//  iAluAccumulator  in   WIDTH          from ALU oAccumulator
//  iAluCarry        in   1              from ALU carry out (0 for logic ops)
//  iAluZero         in   1              from ALU registered zero flag
//  oRspValid        out  1              response available
//  iRspReady        in   1              requester accepts response
//  oRspResult       out  WIDTH          captured accumulator
//  oRspCarry        out  1              captured carry
//  oRspZero         out  1              captured zero flag
//  oCount           out  clog2(D+1)     FIFO occupancy
//  oBusy            out  1              state != IDLE or oCount != 0
// BEHAVIOUR
//  Reset (async, iReset_n=0): FIFO empty, oCount=0, state IDLE, all ALU/response outputs and last-result reg = 0,
//   oRspValid=0, oCmdReady=1, oBusy=0. Reset mid-operation drops queued commands and any pending response.
//  FIFO: push when iCmdValid & oCmdReady; oCmdReady depends only on registered count (no push into full
//   FIFO even if a pop occurs same edge). Pop only from registered count > 0 (no empty bypass).
//   Simultaneous push+pop: count unchanged, order preserved. Pointers wrap mod FIFO_DEPTH.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//   IDLE: if count>0, pop head at the edge; load oAluA (last result if UseAcc, else A), oAluB, oAluOpcode;
//         load wait counter = ALU_LATENCY; -> EXEC.
//   EXEC: ALU outputs held stable; counter decrements each edge; at the edge where counter==0, capture
//         iAluAccumulator/iAluCarry/iAluZero into oRsp* and last-result reg; -> RESP.
//   RESP: oRspValid=1, payload stable; on iRspReady edge -> IDLE (next pop earliest the following edge).
//  ALU outputs retain last issued values in IDLE/RESP (not cleared).
//  Latency (ALU_LATENCY=1, empty FIFO): accept edge E0, issue E1, capture E3 -> oRspValid=1 after E3.
//   General: capture at E0+ALU_LATENCY+2. Throughput: one command per ALU_LATENCY+3 cycles with iRspReady=1.
//  Chained UseAcc uses last-result reg value at the issue edge (previous response, whether consumed or not).
//  No arithmetic in block; widths pass through unchanged. Opcode values are not checked.
// TESTING (bench ALU model: 101 = A+B with carry, registered zero flag, ALU_LATENCY=1)
//  Reset asserted mid-EXEC -> all outputs 0, oCmdReady=1, oCount=0 immediately (async), no stray response.
//  Push {101, A=0x0003, B=0x0004} -> oAluA/B stable through EXEC; oRspValid after E3, result 0x0007, C=0, Z=0.
//  Push {101,0xFFFF,0x0001} then {101,UseAcc,B=0x0005} -> rsp1 0x0000 C=1 Z=1; rsp2 oAluA=0x0000, 0x0005 Z=0.
//  iRspReady=0, offer 6 cmds -> cmd1 in EXEC/RESP, cmds 2-5 queued, oCount=4, oCmdReady=0, rsp1 held stable.
//  Push while IDLE pops with count=2 -> oCount stays 2; later responses returned in push order.
//  Logic opcode 000 with ALU carry model forced 0 -> oRspCarry=0; oBusy=0 only after last response taken.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of a multi-cycle ALU: queues commands in a small FIFO,
// issues one at a time, holds operands for the ALU latency and captures the response.
module alu_op_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                                  iClock,
  input  logic                                  iReset_n,
  input  logic                                  iCmdValid,
  output logic                                  oCmdReady,
  input  logic [2:0]                            iCmdOpcode,
  input  logic [WIDTH-1:0]                      iCmdA,
  input  logic [WIDTH-1:0]                      iCmdB,
  input  logic                                  iCmdUseAcc,
  output logic [WIDTH-1:0]                      oAluA,
  output logic [WIDTH-1:0]                      oAluB,
  output logic [2:0]                            oAluOpcode,
  input  logic [WIDTH-1:0]                      iAluAccumulator,
  input  logic                                  iAluCarry,
  input  logic                                  iAluZero,
  output logic                                  oRspValid,
  input  logic                                  iRspReady,
  output logic [WIDTH-1:0]                      oRspResult,
  output logic                                  oRspCarry,
  output logic                                  oRspZero,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       oCount,
  output logic                                  oBusy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAT_W = $clog2(ALU_LATENCY + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [2:0]       opcode;
    logic             useAcc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t             fifoMem [FIFO_DEPTH];
  cmd_t             cmdIn;
  cmd_t             headCmd;

  logic [1:0]       state, stateNext;
  logic [PTR_W-1:0] wrPtr, wrPtrNext;
  logic [PTR_W-1:0] rdPtr, rdPtrNext;
  logic [CNT_W-1:0] countNext;
  logic [LAT_W-1:0] waitCnt, waitCntNext;
  logic [WIDTH-1:0] lastResult, lastResultNext;

  logic [WIDTH-1:0] aluANext, aluBNext;
  logic [2:0]       aluOpcodeNext;
  logic             rspValidNext;
  logic [WIDTH-1:0] rspResultNext;
  logic             rspCarryNext, rspZeroNext;
  logic             cmdReadyNext, busyNext;

  logic             push, pop;

  assign cmdIn.opcode = iCmdOpcode;
  assign cmdIn.useAcc = iCmdUseAcc;
  assign cmdIn.a      = iCmdA;
  assign cmdIn.b      = iCmdB;

  // Both handshakes look only at registered occupancy: no full-pop passthrough, no empty bypass.
  assign push    = iCmdValid && oCmdReady;
  assign pop     = (state == IDLE) && (oCount != CNT_W'(0));
  assign headCmd = fifoMem[rdPtr];

  // Command storage; payload needs no reset since occupancy gates every read.
  always_ff @(posedge iClock) begin
    if (push) begin
      fifoMem[wrPtr] <= cmdIn;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext      = state;
    wrPtrNext      = wrPtr;
    rdPtrNext      = rdPtr;
    countNext      = oCount;
    waitCntNext    = waitCnt;
    lastResultNext = lastResult;
    aluANext       = oAluA;
    aluBNext       = oAluB;
    aluOpcodeNext  = oAluOpcode;
    rspValidNext   = oRspValid;
    rspResultNext  = oRspResult;
    rspCarryNext   = oRspCarry;
    rspZeroNext    = oRspZero;

    if (push) begin
      wrPtrNext = wrPtr + PTR_W'(1);
    end
    if (pop) begin
      rdPtrNext = rdPtr + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   countNext = oCount + CNT_W'(1);
      2'b01:   countNext = oCount - CNT_W'(1);
      default: countNext = oCount;
    endcase

    case (state)
      IDLE: begin
        if (pop) begin
          aluANext      = headCmd.useAcc ? lastResult : headCmd.a;
          aluBNext      = headCmd.b;
          aluOpcodeNext = headCmd.opcode;
          waitCntNext   = LAT_W'(ALU_LATENCY);
          stateNext     = EXEC;
        end
      end
      EXEC: begin
        // Operands stay put; capture once the ALU latency has elapsed.
        if (waitCnt == LAT_W'(0)) begin
          rspResultNext  = iAluAccumulator;
          rspCarryNext   = iAluCarry;
          rspZeroNext    = iAluZero;
          lastResultNext = iAluAccumulator;
          rspValidNext   = 1'b1;
          stateNext      = RESP;
        end else begin
          waitCntNext = waitCnt - LAT_W'(1);
        end
      end
      RESP: begin
        if (iRspReady) begin
          rspValidNext = 1'b0;
          stateNext    = IDLE;
        end
      end
      default: begin
        rspValidNext = 1'b0;
        stateNext    = IDLE;
      end
    endcase

    cmdReadyNext = (countNext != CNT_W'(FIFO_DEPTH));
    busyNext     = (stateNext != IDLE) || (countNext != CNT_W'(0));
  end

  // State and output registers.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state      <= IDLE;
      wrPtr      <= '0;
      rdPtr      <= '0;
      oCount     <= '0;
      waitCnt    <= '0;
      lastResult <= '0;
      oAluA      <= '0;
      oAluB      <= '0;
      oAluOpcode <= '0;
      oRspValid  <= 1'b0;
      oRspResult <= '0;
      oRspCarry  <= 1'b0;
      oRspZero   <= 1'b0;
      oCmdReady  <= 1'b1;
      oBusy      <= 1'b0;
    end else begin
      state      <= stateNext;
      wrPtr      <= wrPtrNext;
      rdPtr      <= rdPtrNext;
      oCount     <= countNext;
      waitCnt    <= waitCntNext;
      lastResult <= lastResultNext;
      oAluA      <= aluANext;
      oAluB      <= aluBNext;
      oAluOpcode <= aluOpcodeNext;
      oRspValid  <= rspValidNext;
      oRspResult <= rspResultNext;
      oRspCarry  <= rspCarryNext;
      oRspZero   <= rspZeroNext;
      oCmdReady  <= cmdReadyNext;
      oBusy      <= busyNext;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a one-cycle registered ALU model
// (101 = add with carry, 000 = AND with carry 0).
module tb_alu_op_sequencer;

  logic        iClock = 1'b0;
  logic        iReset_n;
  logic        iCmdValid;
  logic        oCmdReady;
  logic [2:0]  iCmdOpcode;
  logic [15:0] iCmdA, iCmdB;
  logic        iCmdUseAcc;
  logic [15:0] oAluA, oAluB;
  logic [2:0]  oAluOpcode;
  logic [15:0] aluAcc;
  logic        aluCarry, aluZero;
  logic        oRspValid;
  logic        iRspReady;
  logic [15:0] oRspResult;
  logic        oRspCarry, oRspZero;
  logic [2:0]  oCount;
  logic        oBusy;

  int nCompared = 0;
  int nMismatch = 0;

  alu_op_sequencer #(.WIDTH(16), .FIFO_DEPTH(4), .ALU_LATENCY(1)) dut (
    .iClock(iClock), .iReset_n(iReset_n),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdOpcode(iCmdOpcode),
    .iCmdA(iCmdA), .iCmdB(iCmdB), .iCmdUseAcc(iCmdUseAcc),
    .oAluA(oAluA), .oAluB(oAluB), .oAluOpcode(oAluOpcode),
    .iAluAccumulator(aluAcc), .iAluCarry(aluCarry), .iAluZero(aluZero),
    .oRspValid(oRspValid), .iRspReady(iRspReady),
    .oRspResult(oRspResult), .oRspCarry(oRspCarry), .oRspZero(oRspZero),
    .oCount(oCount), .oBusy(oBusy)
  );

  always #5 iClock = ~iClock;

  // ALU model: one register stage on result, carry and zero flag
  logic [16:0] aluNext;
  always_comb begin
    case (oAluOpcode)
      3'b101:  aluNext = {1'b0, oAluA} + {1'b0, oAluB};
      3'b000:  aluNext = {1'b0, oAluA & oAluB};
      default: aluNext = {1'b0, oAluA ^ oAluB};
    endcase
  end
  always_ff @(posedge iClock) begin
    aluAcc   <= aluNext[15:0];
    aluCarry <= aluNext[16];
    aluZero  <= (aluNext[15:0] == 16'h0000);
  end

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic acc, input logic [15:0] a, input logic [15:0] b);
    iCmdValid  = 1'b1;
    iCmdOpcode = op;
    iCmdUseAcc = acc;
    iCmdA      = a;
    iCmdB      = b;
  endtask

  // Bounded wait for a response, then check its payload
  task automatic waitRsp(input string tag, input logic [15:0] r, input logic c, input logic z);
    int n;
    n = 0;
    while (oRspValid !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(oRspValid), 32'(1));
    chk({tag, "_result"}, 32'(oRspResult), 32'(r));
    chk({tag, "_carry"}, 32'(oRspCarry), 32'(c));
    chk({tag, "_zero"}, 32'(oRspZero), 32'(z));
  endtask

  initial begin
    iReset_n   = 1'b1;
    iCmdValid  = 1'b0;
    iCmdOpcode = 3'b000;
    iCmdA      = 16'h0000;
    iCmdB      = 16'h0000;
    iCmdUseAcc = 1'b0;
    iRspReady  = 1'b0;
    #2 iReset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(oCmdReady), 32'(1));
    chk("rst_count", 32'(oCount), 32'(0));
    chk("rst_busy", 32'(oBusy), 32'(0));
    chk("rst_rspvalid", 32'(oRspValid), 32'(0));
    chk("rst_alua", 32'(oAluA), 32'(0));
    chk("rst_rspresult", 32'(oRspResult), 32'(0));
    step();
    step();
    iReset_n = 1'b1;

    // Single add 3 + 4
    drive(3'b101, 1'b0, 16'h0003, 16'h0004);
    step();
    chk("s1_count_e0", 32'(oCount), 32'(1));
    chk("s1_busy_e0", 32'(oBusy), 32'(1));
    iCmdValid = 1'b0;
    step();
    chk("s1_alua_e1", 32'(oAluA), 32'h3);
    chk("s1_alub_e1", 32'(oAluB), 32'h4);
    chk("s1_op_e1", 32'(oAluOpcode), 32'h5);
    chk("s1_count_e1", 32'(oCount), 32'(0));
    step();
    chk("s1_alua_e2", 32'(oAluA), 32'h3);
    chk("s1_rspvalid_e2", 32'(oRspValid), 32'(0));
    step();
    chk("s1_rspvalid_e3", 32'(oRspValid), 32'(1));
    chk("s1_result", 32'(oRspResult), 32'h7);
    chk("s1_carry", 32'(oRspCarry), 32'(0));
    chk("s1_zero", 32'(oRspZero), 32'(0));
    iRspReady = 1'b1;
    step();
    chk("s1_rspvalid_e4", 32'(oRspValid), 32'(0));
    chk("s1_busy_e4", 32'(oBusy), 32'(0));

    // Overflow then chained UseAcc
    drive(3'b101, 1'b0, 16'hFFFF, 16'h0001);
    step();
    drive(3'b101, 1'b1, 16'h1234, 16'h0005);
    step();
    chk("s2_count_e1", 32'(oCount), 32'(1));
    chk("s2_alua_e1", 32'(oAluA), 32'hFFFF);
    iCmdValid = 1'b0;
    step();
    step();
    chk("s2_r1_valid", 32'(oRspValid), 32'(1));
    chk("s2_r1_result", 32'(oRspResult), 32'h0);
    chk("s2_r1_carry", 32'(oRspCarry), 32'(1));
    chk("s2_r1_zero", 32'(oRspZero), 32'(1));
    step();
    chk("s2_rspvalid_e4", 32'(oRspValid), 32'(0));
    step();
    chk("s2_alua_chain", 32'(oAluA), 32'h0);
    chk("s2_alub_chain", 32'(oAluB), 32'h5);
    step();
    step();
    chk("s2_r2_valid", 32'(oRspValid), 32'(1));
    chk("s2_r2_result", 32'(oRspResult), 32'h5);
    chk("s2_r2_carry", 32'(oRspCarry), 32'(0));
    chk("s2_r2_zero", 32'(oRspZero), 32'(0));
    step();

    // Backpressure: six offers, FIFO fills with four, first response held
    iRspReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(3'b101, 1'b0, 16'(16 * (i + 1)), 16'(i + 1));
      step();
    end
    iCmdValid = 1'b0;
    chk("s3_count_full", 32'(oCount), 32'(4));
    chk("s3_ready_full", 32'(oCmdReady), 32'(0));
    chk("s3_rspvalid", 32'(oRspValid), 32'(1));
    chk("s3_r0_result", 32'(oRspResult), 32'h11);
    step();
    step();
    chk("s3_r0_held", 32'(oRspResult), 32'h11);
    chk("s3_valid_held", 32'(oRspValid), 32'(1));
    chk("s3_count_held", 32'(oCount), 32'(4));
    iRspReady = 1'b1;
    step();
    for (int k = 1; k < 5; k++) begin
      waitRsp($sformatf("s3_r%0d", k), 16'(17 * (k + 1)), 1'b0, 1'b0);
      step();
    end

    // Push coinciding with a pop at count 2, chained command and logic opcode
    iRspReady = 1'b0;
    drive(3'b101, 1'b0, 16'h0100, 16'h0001);
    step();
    drive(3'b101, 1'b0, 16'h8000, 16'h8000);
    step();
    drive(3'b101, 1'b1, 16'h0000, 16'h0002);
    step();
    iCmdValid = 1'b0;
    step();
    waitRsp("s4_ra", 16'h0101, 1'b0, 1'b0);
    chk("s4_count_resp", 32'(oCount), 32'(2));
    iRspReady = 1'b1;
    step();
    chk("s4_count_idle", 32'(oCount), 32'(2));
    chk("s4_rspvalid_idle", 32'(oRspValid), 32'(0));
    drive(3'b000, 1'b0, 16'hFF00, 16'hF0F0);
    step();
    iCmdValid = 1'b0;
    chk("s4_count_pushpop", 32'(oCount), 32'(2));
    chk("s4_alua_b", 32'(oAluA), 32'h8000);
    waitRsp("s4_rb", 16'h0000, 1'b1, 1'b1);
    step();
    waitRsp("s4_rc", 16'h0002, 1'b0, 1'b0);
    step();
    waitRsp("s4_rd", 16'hF000, 1'b0, 1'b0);
    chk("s4_busy_before", 32'(oBusy), 32'(1));
    step();
    chk("s4_busy_after", 32'(oBusy), 32'(0));
    chk("s4_rspvalid_after", 32'(oRspValid), 32'(0));

    // Asynchronous reset while a command executes and another is queued
    drive(3'b101, 1'b0, 16'h1111, 16'h2222);
    step();
    drive(3'b101, 1'b0, 16'h0001, 16'h0001);
    step();
    iCmdValid = 1'b0;
    step();
    iReset_n = 1'b0;
    #1;
    chk("s5_alua", 32'(oAluA), 32'(0));
    chk("s5_alub", 32'(oAluB), 32'(0));
    chk("s5_op", 32'(oAluOpcode), 32'(0));
    chk("s5_rspresult", 32'(oRspResult), 32'(0));
    chk("s5_rspvalid", 32'(oRspValid), 32'(0));
    chk("s5_count", 32'(oCount), 32'(0));
    chk("s5_ready", 32'(oCmdReady), 32'(1));
    chk("s5_busy", 32'(oBusy), 32'(0));
    step();
    step();
    iReset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("s5_nostray_%0d", i), 32'({oRspValid, oBusy, oCount}), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
